// File: rtl/top_ram_stream_if.sv
// Bundle of the load/replay streams and the top-RAM port for top_ram_stream_ctrl.
// The master is the environment (producer, consumer and RAM); the slave is the controller.
interface top_ram_stream_if #(
    parameter int unsigned TOPSIZEWIDTH = 10,
    parameter int unsigned TOPWIDTH     = 32
);
    logic                    load_start;
    logic [TOPSIZEWIDTH:0]   load_len;
    logic [TOPWIDTH-1:0]     in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    rd_start;
    logic [TOPSIZEWIDTH:0]   rd_len;
    logic [TOPWIDTH-1:0]     out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic [TOPWIDTH-1:0]     ram_data;
    logic [TOPSIZEWIDTH-1:0] ram_wraddress;
    logic                    ram_wren;
    logic [TOPSIZEWIDTH-1:0] ram_rdaddress;
    logic [TOPWIDTH-1:0]     ram_q;

    modport master (
        output load_start, load_len, in_data, in_valid, rd_start, rd_len, out_ready, ram_q,
        input  in_ready, out_data, out_valid, out_last, busy,
               ram_data, ram_wraddress, ram_wren, ram_rdaddress
    );

    modport slave (
        input  load_start, load_len, in_data, in_valid, rd_start, rd_len, out_ready, ram_q,
        output in_ready, out_data, out_valid, out_last, busy,
               ram_data, ram_wraddress, ram_wren, ram_rdaddress
    );
endinterface

// File: rtl/top_ram_stream_ctrl.sv
// Loads a row into the top RAM from a valid/ready stream and replays a prefix of it,
// hiding the RAM's 2-cycle read latency behind a 4-entry credit-managed output FIFO.
module top_ram_stream_ctrl #(
    parameter int unsigned TOPSIZE      = 1024,
    parameter int unsigned TOPSIZEWIDTH = 10,
    parameter int unsigned TOPWIDTH     = 32
) (
    input logic             clock,
    input logic             reset,
    top_ram_stream_if.slave bus
);
    localparam int unsigned LW    = TOPSIZEWIDTH + 1;
    localparam int unsigned FD    = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_READ = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [LW-1:0]           len_q, len_d;
    logic [LW-1:0]           acc_q, acc_d;
    logic [LW-1:0]           issued_q, issued_d;
    logic [LW-1:0]           popped_q, popped_d;
    logic [1:0]              vpipe_q, vpipe_d;
    logic [TOPWIDTH-1:0]     fifo_q [FD];
    logic [TOPWIDTH-1:0]     fifo_d [FD];
    logic [PW-1:0]           wptr_q, wptr_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TOPWIDTH-1:0]     ram_data_q, ram_data_d;
    logic [TOPSIZEWIDTH-1:0] ram_wraddr_q, ram_wraddr_d;
    logic                    ram_wren_q, ram_wren_d;

    logic          in_ready_c, in_hs, out_valid_c, push, pop, issue;
    logic [CW-1:0] inflight;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > LW'(TOPSIZE)) ? LW'(TOPSIZE) : l;
    endfunction

    // Credit rule: FIFO occupancy plus reads in flight never exceeds the FIFO depth.
    always_comb begin
        in_ready_c  = (state_q == S_LOAD) && (acc_q < len_q);
        in_hs       = bus.in_valid && in_ready_c;
        out_valid_c = (cnt_q != '0);
        pop         = out_valid_c && bus.out_ready;
        push        = vpipe_q[1];
        inflight    = CW'(vpipe_q[0]) + CW'(vpipe_q[1]);
        issue       = (state_q == S_READ) && (issued_q < len_q) && ((cnt_q + inflight) < CW'(FD));
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        acc_d        = acc_q;
        issued_d     = issued_q;
        popped_d     = popped_q;
        vpipe_d      = {vpipe_q[0], issue};
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        ram_data_d   = ram_data_q;
        ram_wraddr_d = ram_wraddr_q;
        ram_wren_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    if (bus.load_len != '0) begin
                        state_d = S_LOAD;
                        len_d   = clamp_len(bus.load_len);
                        acc_d   = '0;
                    end
                end else if (bus.rd_start && (bus.rd_len != '0)) begin
                    state_d  = S_READ;
                    len_d    = clamp_len(bus.rd_len);
                    issued_d = '0;
                    popped_d = '0;
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    ram_data_d   = bus.in_data;
                    ram_wraddr_d = acc_q[TOPSIZEWIDTH-1:0];
                    ram_wren_d   = 1'b1;
                    acc_d        = acc_q + LW'(1);
                end
                // Leave one cycle after the last write so it never overlaps a read address.
                if (acc_q == len_q) state_d = S_IDLE;
            end
            S_READ: begin
                if (issue) issued_d = issued_q + LW'(1);
                if (pop) begin
                    popped_d = popped_q + LW'(1);
                    if (popped_q == len_q - LW'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            fifo_d[wptr_q] = bus.ram_q;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) rptr_d = rptr_q + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            acc_q        <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            vpipe_q      <= '0;
            fifo_q       <= '{default: '0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            ram_data_q   <= '0;
            ram_wraddr_q <= '0;
            ram_wren_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            acc_q        <= acc_d;
            issued_q     <= issued_d;
            popped_q     <= popped_d;
            vpipe_q      <= vpipe_d;
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            ram_data_q   <= ram_data_d;
            ram_wraddr_q <= ram_wraddr_d;
            ram_wren_q   <= ram_wren_d;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_data      = fifo_q[rptr_q];
    assign bus.out_last      = out_valid_c && (popped_q == len_q - LW'(1));
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.ram_data      = ram_data_q;
    assign bus.ram_wraddress = ram_wraddr_q;
    assign bus.ram_wren      = ram_wren_q;
    assign bus.ram_rdaddress = issued_q[TOPSIZEWIDTH-1:0];
endmodule

// File: doc/top_ram_stream_ctrl.md
# top_ram_stream_ctrl

Streaming front/back end for the top-row RAM in the LU8PEEng datapath. It loads a row of up to TOPSIZE words from a valid/ready input stream into the top RAM's write port. On request, it replays a prefix of that row onto a valid/ready output stream. It owns both RAM address ports and hides the RAM's 2-cycle registered read latency behind a 4-entry output FIFO, so the consumer sees full-throughput, backpressurable data.

## Interface
- TOPSIZE, 1024, RAM depth in words
- TOPSIZEWIDTH, 10, RAM address width
- TOPWIDTH, 32, word width

Ports:
- clock  in  1  single clock for the block and the RAM
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle request to load a row; honoured only in IDLE
- load_len  in  TOPSIZEWIDTH+1  words to load; sampled with load_start
- in_data  in  TOPWIDTH  input word
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts in_data this cycle
- rd_start  in  1  one-cycle request to replay; honoured only in IDLE
- rd_len  in  TOPSIZEWIDTH+1  words to replay, starting at address 0; sampled with rd_start
- out_data  out  TOPWIDTH  output word (FIFO head)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_last  out  1  high with the final word of a replay
- busy  out  1  high whenever state is not IDLE
- ram_data  out  TOPWIDTH  to RAM data
- ram_wraddress  out  TOPSIZEWIDTH  to RAM write address
- ram_wren  out  1  to RAM write enable
- ram_rdaddress  out  TOPSIZEWIDTH  to RAM read address
- ram_q  in  TOPWIDTH  from RAM; valid 2 cycles after the address is presented

## Operation
- States: IDLE, LOAD, READ. Reset forces IDLE. All outputs reset to 0.
- In IDLE:
  - load_start wins over a simultaneous rd_start.
  - A length of 0 is a no-op and the state stays IDLE.
  - A length greater than TOPSIZE is clamped to TOPSIZE.
  - start pulses are ignored outside IDLE.
- LOAD:
  - in_ready=1 while accepted < len.
  - Each handshake registers ram_data=in_data, ram_wraddress=accepted count, ram_wren=1 for the next cycle. ram_wren=0 otherwise.
  - Write addresses run 0,1,…,len-1 with no wrap.
  - The state returns to IDLE in the cycle after the last write is driven, so the last write and the first read address are never in the same cycle.
- READ:
  - An issue counter drives ram_rdaddress.
  - A read is issued when issued < len and (fifo_count + in_flight) < 4.
  - A 2-stage valid shift register tracks in-flight reads. When stage 2 is set, ram_q is pushed into the FIFO.
  - out_valid = FIFO non-empty. A pop occurs on out_valid & out_ready.
  - out_last = out_valid & (popped == len-1).
  - After the final pop, the state returns to IDLE on the next cycle.
- FIFO is 4 entries. Overflow cannot occur by the credit rule. A push and a pop in the same cycle leave the count unchanged.
- Reset mid-operation:
  - Returns to IDLE and clears the FIFO, valid pipe and counters.
  - In-flight ram_q values are discarded.
  - RAM contents are untouched.

## Timing
- rd_start is sampled in cycle 0. READ is entered and address 0 is issued in cycle 1. ram_q is pushed at the end of cycle 3. out_valid first rises in cycle 4.
- With out_ready held high, one word per cycle follows with no bubbles.
- load_start is sampled in cycle 0. in_ready rises in cycle 1. A handshake in cycle k produces ram_wren in cycle k+1.
- After the last handshake in cycle k, busy falls in cycle k+2, and rd_start is honoured in cycle k+2.
- When out_ready drops, at most 4 words are buffered, the issue pauses, and no data is lost or duplicated.

## Test plan
- Load 8 words 0xA0..0xA7 with in_valid held high, then replay 8 -> ram_wren for 8 consecutive cycles at addresses 0..7. out_valid first in cycle 4 after rd_start, data A0..A7 back to back, out_last only on A7.
- Replay 16 with out_ready toggling 1,0,0,1,… -> every word delivered exactly once, in order. ram_rdaddress never leads pops by more than 4.
- load_start and rd_start in the same IDLE cycle -> LOAD entered, rd_start dropped. rd_start during LOAD -> ignored, busy stays 1.
- load_len=0 -> busy stays 0. load_len=2000 -> exactly 1024 writes at addresses 0..1023, then IDLE.
- Reset asserted in READ after 3 issues -> next cycle IDLE, out_valid=0, FIFO empty. A new replay of 2 returns words 0 and 1 with correct out_last.
